// File: rtl/cp0_int_unit.sv
// CP0 interrupt/exception unit: Count/Compare timer, Status, Cause, EPC,
// synchronised external interrupt edge capture and interrupt acknowledge.
module cp0_int_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  irq_in,
    input  logic        mtc0,
    input  logic [4:0]  sel,
    input  logic [31:0] wdata,
    input  logic [31:0] pc_in,
    input  logic        exc,
    input  logic        cause_sel,
    input  logic        eret,
    input  logic        inta,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] epc,
    output logic        int_req
);

    localparam logic [4:0] SEL_COUNT   = 5'd9;
    localparam logic [4:0] SEL_COMPARE = 5'd11;
    localparam logic [4:0] SEL_STATUS  = 5'd12;
    localparam logic [4:0] SEL_CAUSE   = 5'd13;
    localparam logic [4:0] SEL_EPC     = 5'd14;

    localparam logic [4:0] EXC_CODE_INT = 5'd0;
    localparam logic [4:0] EXC_CODE_SYS = 5'd8;

    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic [31:0] epc_reg, epc_next;
    logic        ie_reg, ie_next;
    logic        exl_reg, exl_next;
    logic [7:0]  im_reg, im_next;
    logic [7:0]  ip_reg, ip_next;
    logic [4:0]  exc_code_reg, exc_code_next;
    logic [3:0]  sync1_reg, sync2_reg, hist_reg;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        timer_hit;
    logic [3:0]  irq_rise;
    logic [7:0]  ack_pend, ack_sel;
    logic [7:0]  ip_set, ip_clr, ip_wr;
    logic [31:0] cause_word;

    assign wr_count   = mtc0 && (sel == SEL_COUNT);
    assign wr_compare = mtc0 && (sel == SEL_COMPARE);
    assign wr_status  = mtc0 && (sel == SEL_STATUS);
    assign wr_cause   = mtc0 && (sel == SEL_CAUSE);
    assign wr_epc     = mtc0 && (sel == SEL_EPC);

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 4'd0;
            sync2_reg <= 4'd0;
            hist_reg  <= 4'd0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign irq_rise  = sync2_reg & ~hist_reg;
    assign timer_hit = (count_reg == compare_reg);

    // Acknowledge isolates the lowest pending-and-enabled bit.
    assign ack_pend = ip_reg & im_reg;
    assign ack_sel  = inta ? (ack_pend & (~ack_pend + 8'd1)) : 8'd0;

    // A Compare write suppresses a same-cycle timer match on IP[7].
    assign ip_set = {timer_hit & ~wr_compare, 1'b0, irq_rise, 2'b00};
    assign ip_clr = ack_sel | {wr_compare, 7'd0};
    assign ip_wr  = {6'd0, wr_cause, wr_cause};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ip
            assign ip_next[gi] = ip_set[gi] ? 1'b1 :
                                 ip_clr[gi] ? 1'b0 :
                                 ip_wr[gi]  ? wdata[8+gi] :
                                              ip_reg[gi];
        end
    endgenerate

    always_comb begin
        count_next    = wr_count ? wdata : count_reg + 32'd1;
        compare_next  = wr_compare ? wdata : compare_reg;
        ie_next       = ie_reg;
        im_next       = im_reg;
        exl_next      = exl_reg;
        epc_next      = epc_reg;
        exc_code_next = exc_code_reg;

        if (wr_status) begin
            ie_next  = wdata[0];
            im_next  = wdata[15:8];
            exl_next = wdata[1];
        end
        if (wr_epc) begin
            epc_next = wdata;
        end
        if (eret) begin
            exl_next = 1'b0;
        end
        // Exception entry overrides eret and software writes of the same fields.
        if (exc) begin
            exl_next      = 1'b1;
            epc_next      = pc_in;
            exc_code_next = cause_sel ? EXC_CODE_INT : EXC_CODE_SYS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg    <= 32'd0;
            compare_reg  <= 32'hFFFF_FFFF;
            epc_reg      <= 32'd0;
            ie_reg       <= 1'b0;
            exl_reg      <= 1'b0;
            im_reg       <= 8'd0;
            ip_reg       <= 8'd0;
            exc_code_reg <= 5'd0;
        end else begin
            count_reg    <= count_next;
            compare_reg  <= compare_next;
            epc_reg      <= epc_next;
            ie_reg       <= ie_next;
            exl_reg      <= exl_next;
            im_reg       <= im_next;
            ip_reg       <= ip_next;
            exc_code_reg <= exc_code_next;
        end
    end

    assign status     = {16'd0, im_reg, 6'd0, exl_reg, ie_reg};
    assign cause_word = {16'd0, ip_reg, 1'b0, exc_code_reg, 2'b00};
    assign epc        = epc_reg;
    assign int_req    = ie_reg & ~exl_reg & (|(ip_reg & im_reg));

    always_comb begin
        rdata = 32'd0;
        case (sel)
            SEL_COUNT:   rdata = count_reg;
            SEL_COMPARE: rdata = compare_reg;
            SEL_STATUS:  rdata = status;
            SEL_CAUSE:   rdata = cause_word;
            SEL_EPC:     rdata = epc_reg;
            default:     rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_unit.sv
// Bench for cp0_int_unit: directed vector table, hand-written timer and
// reset sequences, then randomised traffic against a behavioural model.
module tb_cp0_int_unit;

    logic        clk, reset;
    logic [3:0]  irq_in;
    logic        mtc0, exc, cause_sel, eret, inta;
    logic [4:0]  sel;
    logic [31:0] wdata, pc_in;
    logic [31:0] rdata, status, epc;
    logic        int_req;

    int checks = 0;
    int errors = 0;

    cp0_int_unit dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .mtc0(mtc0), .sel(sel),
        .wdata(wdata), .pc_in(pc_in), .exc(exc), .cause_sel(cause_sel),
        .eret(eret), .inta(inta), .rdata(rdata), .status(status), .epc(epc),
        .int_req(int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mtc0;
        logic [4:0]  sel;
        logic [31:0] wdata;
        logic        exc, cause_sel, eret, inta;
        logic [3:0]  irq;
        logic [31:0] pc;
        logic [31:0] e_status, e_epc, e_rdata;
        logic        e_int;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic m, logic [4:0] s, logic [31:0] d, logic e, logic cs,
                                logic er, logic ia, logic [3:0] irq, logic [31:0] pc,
                                logic [31:0] st, logic [31:0] ep, logic [31:0] rd, logic ir);
        vec_t v;
        v.mtc0 = m; v.sel = s; v.wdata = d; v.exc = e; v.cause_sel = cs; v.eret = er;
        v.inta = ia; v.irq = irq; v.pc = pc; v.e_status = st; v.e_epc = ep;
        v.e_rdata = rd; v.e_int = ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic m, input logic [4:0] s, input logic [31:0] d);
        mtc0 = m; sel = s; wdata = d; exc = 1'b0; eret = 1'b0; inta = 1'b0;
        step();
    endtask

    task automatic peek(input logic [4:0] s, output logic [31:0] v);
        sel = s;
        #1;
        v = rdata;
    endtask

    // Behavioural model state
    logic [31:0] m_count, m_compare, m_epc;
    logic        m_ie, m_exl;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_code;
    logic [3:0]  m_s1, m_s2, m_s3;   // irq samples taken 1, 2 and 3 edges ago

    task automatic model_reset();
        m_count = 0; m_compare = 32'hFFFF_FFFF; m_epc = 0;
        m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0; m_code = 0;
        m_s1 = 0; m_s2 = 0; m_s3 = 0;
    endtask

    function automatic logic [31:0] m_status();
        return {16'h0, m_im, 6'h0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] s);
        case (s)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return {16'h0, m_ip, 1'b0, m_code, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [7:0] n_ip, irq_bits;
        logic       cmp_wr, set_b, clr_b;
        int         first;
        cmp_wr   = mtc0 && (sel == 5'd11);
        irq_bits = {2'b00, m_s2 & ~m_s3, 2'b00};
        first = -1;
        for (int i = 0; i < 8; i++)
            if (first < 0 && m_ip[i] && m_im[i]) first = i;
        for (int i = 0; i < 8; i++) begin
            set_b = irq_bits[i];
            if (i == 7) set_b = (m_count == m_compare) && !cmp_wr;
            clr_b = (inta && i == first) || (i == 7 && cmp_wr);
            if (set_b)                              n_ip[i] = 1'b1;
            else if (clr_b)                         n_ip[i] = 1'b0;
            else if (i < 2 && mtc0 && sel == 5'd13) n_ip[i] = wdata[8+i];
            else                                    n_ip[i] = m_ip[i];
        end
        m_ip = n_ip;
        if (mtc0 && sel == 5'd12) begin
            m_ie = wdata[0]; m_im = wdata[15:8]; m_exl = wdata[1];
        end
        if (eret) m_exl = 1'b0;
        if (mtc0 && sel == 5'd14) m_epc = wdata;
        if (exc) begin
            m_exl = 1'b1; m_epc = pc_in; m_code = cause_sel ? 5'd0 : 5'd8;
        end
        m_count = (mtc0 && sel == 5'd9) ? wdata : m_count + 32'd1;
        if (cmp_wr) m_compare = wdata;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq_in;
    endtask

    logic [31:0] v;
    logic        m_int;

    initial begin
        tbl[0]  = mk(1, 12, 32'h401,      0, 0, 0, 0, 4'h0, 0,        32'h401,  0,        32'h401,      0);
        tbl[1]  = mk(0, 13, 0,            0, 0, 0, 0, 4'h1, 0,        32'h401,  0,        32'h0,        0);
        tbl[2]  = mk(0, 13, 0,            0, 0, 0, 0, 4'h1, 0,        32'h401,  0,        32'h0,        0);
        tbl[3]  = mk(0, 13, 0,            0, 0, 0, 0, 4'h1, 0,        32'h401,  0,        32'h400,      1);
        tbl[4]  = mk(0, 14, 0,            1, 1, 0, 0, 4'h1, 32'h40,   32'h403,  32'h40,   32'h40,       0);
        tbl[5]  = mk(0, 13, 0,            0, 0, 0, 0, 4'h1, 0,        32'h403,  32'h40,   32'h400,      0);
        tbl[6]  = mk(0, 12, 0,            0, 0, 1, 0, 4'h1, 0,        32'h401,  32'h40,   32'h401,      1);
        tbl[7]  = mk(1, 12, 32'h1401,     0, 0, 0, 0, 4'h1, 0,        32'h1401, 32'h40,   32'h1401,     1);
        tbl[8]  = mk(0, 13, 0,            0, 0, 0, 0, 4'h5, 0,        32'h1401, 32'h40,   32'h400,      1);
        tbl[9]  = mk(0, 13, 0,            0, 0, 0, 0, 4'h5, 0,        32'h1401, 32'h40,   32'h400,      1);
        tbl[10] = mk(0, 13, 0,            0, 0, 0, 0, 4'h5, 0,        32'h1401, 32'h40,   32'h1400,     1);
        tbl[11] = mk(0, 13, 0,            0, 0, 0, 1, 4'h5, 0,        32'h1401, 32'h40,   32'h1000,     1);
        tbl[12] = mk(0, 13, 0,            0, 0, 0, 1, 4'h5, 0,        32'h1401, 32'h40,   32'h0,        0);
        tbl[13] = mk(0, 13, 0,            0, 0, 0, 1, 4'h5, 0,        32'h1401, 32'h40,   32'h0,        0);
        tbl[14] = mk(1, 13, 32'hFFFF_FFFF,0, 0, 0, 0, 4'h5, 0,        32'h1401, 32'h40,   32'h300,      0);
        tbl[15] = mk(1, 13, 0,            0, 0, 0, 0, 4'h5, 0,        32'h1401, 32'h40,   32'h0,        0);
        tbl[16] = mk(1, 12, 0,            1, 0, 0, 0, 4'h5, 32'h1234, 32'h2,    32'h1234, 32'h2,        0);
        tbl[17] = mk(0, 13, 0,            0, 0, 0, 0, 4'h5, 0,        32'h2,    32'h1234, 32'h20,       0);
        tbl[18] = mk(0, 13, 0,            1, 1, 1, 0, 4'h5, 32'h88,   32'h2,    32'h88,   32'h0,        0);
        tbl[19] = mk(1, 14, 32'hDEAD,     1, 0, 0, 0, 4'h5, 32'h99,   32'h2,    32'h99,   32'h99,       0);
        tbl[20] = mk(1, 14, 32'hCAFE_0000,0, 0, 0, 0, 4'h5, 0,        32'h2,    32'hCAFE_0000, 32'hCAFE_0000, 0);
        tbl[21] = mk(1, 12, 32'hFFFF_FFFF,0, 0, 0, 0, 4'h5, 0,        32'hFF03, 32'hCAFE_0000, 32'hFF03,     0);
        tbl[22] = mk(1, 5,  32'h1234,     0, 0, 0, 0, 4'h5, 0,        32'hFF03, 32'hCAFE_0000, 32'h0,        0);
        tbl[23] = mk(0, 9,  0,            0, 0, 0, 0, 4'h5, 0,        32'hFF03, 32'hCAFE_0000, 32'h18,       0);
        tbl[24] = mk(0, 11, 0,            0, 0, 0, 0, 4'h5, 0,        32'hFF03, 32'hCAFE_0000, 32'hFFFF_FFFF,0);

        reset = 1'b1; irq_in = 0; mtc0 = 0; sel = 0; wdata = 0; pc_in = 0;
        exc = 0; cause_sel = 0; eret = 0; inta = 0;
        step(); step();
        reset = 1'b0;
        chk("reset_status", status, 32'h0);
        chk("reset_epc", epc, 32'h0);
        chk("reset_int_req", int_req, 0);
        peek(5'd11, v); chk("reset_compare", v, 32'hFFFF_FFFF);
        peek(5'd9, v);  chk("reset_count", v, 32'h0);
        peek(5'd13, v); chk("reset_cause", v, 32'h0);

        for (int i = 0; i < 25; i++) begin
            mtc0 = tbl[i].mtc0; sel = tbl[i].sel; wdata = tbl[i].wdata; exc = tbl[i].exc;
            cause_sel = tbl[i].cause_sel; eret = tbl[i].eret; inta = tbl[i].inta;
            irq_in = tbl[i].irq; pc_in = tbl[i].pc;
            step();
            chk($sformatf("vec%0d_status", i), status, tbl[i].e_status);
            chk($sformatf("vec%0d_epc", i), epc, tbl[i].e_epc);
            chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("vec%0d_int_req", i), int_req, tbl[i].e_int);
            $display("vec %0d sel=%0d rdata=%h status=%h epc=%h int_req=%b",
                     i, sel, rdata, status, epc, int_req);
        end

        // Timer match on Count == Compare, cleared by writing Compare
        op(1, 5'd9, 32'h10);
        peek(5'd9, v); chk("timer_count_load", v, 32'h10);
        op(1, 5'd11, 32'h14);
        peek(5'd11, v); chk("timer_compare_load", v, 32'h14);
        op(0, 5'd9, 0); op(0, 5'd9, 0); op(0, 5'd9, 0);
        peek(5'd9, v);  chk("timer_count_at_match", v, 32'h14);
        peek(5'd13, v); chk("timer_ip7_before", v[15], 0);
        op(0, 5'd9, 0);
        peek(5'd9, v);  chk("timer_count_after", v, 32'h15);
        peek(5'd13, v); chk("timer_ip7_set", v[15], 1);
        op(1, 5'd11, 32'h100);
        peek(5'd13, v); chk("timer_ip7_cleared", v[15], 0);
        $display("timer sequence done");

        // Compare write coinciding with a match: the clear wins
        op(1, 5'd9, 32'h2E);
        op(1, 5'd11, 32'h30);
        op(0, 5'd9, 0);
        peek(5'd9, v);  chk("clrwin_count", v, 32'h30);
        op(1, 5'd11, 32'h30);
        peek(5'd13, v); chk("clrwin_ip7", v[15], 0);
        op(0, 5'd9, 0);
        peek(5'd13, v); chk("clrwin_ip7_next", v[15], 0);
        $display("compare clear-wins sequence done");

        // Count wraps to zero
        op(1, 5'd9, 32'hFFFF_FFFF);
        peek(5'd9, v); chk("wrap_count_max", v, 32'hFFFF_FFFF);
        op(0, 5'd9, 0);
        peek(5'd9, v); chk("wrap_count_zero", v, 32'h0);
        $display("count wrap sequence done");

        // Reset in the middle of an exception with IP[3] pending
        irq_in = 4'b0111;
        op(0, 5'd13, 0); op(0, 5'd13, 0); op(0, 5'd13, 0);
        peek(5'd13, v); chk("midrst_ip3_pending", v[11], 1);
        chk("midrst_exl_set", status[1], 1);
        #3 reset = 1'b1;
        #1;
        chk("midrst_status", status, 32'h0);
        chk("midrst_epc", epc, 32'h0);
        chk("midrst_int_req", int_req, 0);
        peek(5'd13, v); chk("midrst_cause", v, 32'h0);
        peek(5'd11, v); chk("midrst_compare", v, 32'hFFFF_FFFF);
        peek(5'd9, v);  chk("midrst_count", v, 32'h0);
        step();
        reset = 1'b0;
        op(0, 5'd13, 0); op(0, 5'd13, 0);
        peek(5'd13, v); chk("postrst_no_edge_yet", v, 32'h0);
        op(0, 5'd13, 0);
        peek(5'd13, v); chk("postrst_new_edge", v, 32'h1C00);
        $display("mid-operation reset sequence done");

        // Randomised traffic against the model
        irq_in = 0; mtc0 = 0; exc = 0; eret = 0; inta = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            mtc0 = ($urandom_range(3) == 0);
            case ($urandom_range(7))
                0: sel = 5'd9;
                1: sel = 5'd11;
                2: sel = 5'd12;
                3: sel = 5'd13;
                4: sel = 5'd14;
                5: sel = 5'd12;
                6: sel = 5'd13;
                default: sel = 5'($urandom_range(31));
            endcase
            wdata = $urandom;
            if (sel == 5'd11 && $urandom_range(1) == 1) wdata = m_count + 32'($urandom_range(4));
            if (sel == 5'd9 && $urandom_range(1) == 1)  wdata = m_compare - 32'($urandom_range(3));
            exc       = ($urandom_range(15) == 0);
            cause_sel = 1'($urandom_range(1));
            eret      = ($urandom_range(15) == 0);
            inta      = ($urandom_range(5) == 0);
            pc_in     = $urandom;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(11) == 0) irq_in[b] = ~irq_in[b];
            model_step();
            step();
            m_int = m_ie & ~m_exl & (|(m_ip & m_im));
            chk("rnd_status", status, m_status());
            chk("rnd_epc", epc, m_epc);
            chk("rnd_rdata", rdata, m_read(sel));
            chk("rnd_int_req", int_req, m_int);
            $display("rnd %0d sel=%0d mtc0=%b exc=%b eret=%b inta=%b rdata=%h int_req=%b",
                     n, sel, mtc0, exc, eret, inta, rdata, int_req);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_int_unit.md
CP0_INT_UNIT -- requirements
Module: cp0_int_unit

Interface
REQ-001 Clock and reset (already decided): reset reset, asynchronous, active-high; clock clk.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces all registers to reset values.
REQ-004 irq_in  in  4  external interrupt lines, level, asynchronous to clk.
REQ-005 mtc0  in  1  write strobe: wdata goes to the register selected by sel.
REQ-006 sel  in  5  CP0 register number (instruction rd field), used for both read and write.
REQ-007 wdata  in  32  write data (GPR rt value).
REQ-008 pc_in  in  32  PC to save on exception entry.
REQ-009 exc  in  1  exception-entry strobe.
REQ-010 cause_sel  in  1  exception code select during exc: 1 = hardware interrupt (code 0), 0 = syscall (code 8).
REQ-011 eret  in  1  exception-return strobe.
REQ-012 inta  in  1  interrupt-acknowledge strobe.
REQ-013 rdata  out  32  combinational read of the register selected by sel; unmapped sel reads 0.
REQ-014 status  out  32  current Status register.
REQ-015 epc  out  32  current EPC register.
REQ-016 int_req  out  1  combinational: Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).

Function
REQ-017 The register map SHALL be: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
- Writes to any other number are ignored.
REQ-018 Status SHALL have IE at bit 0, EXL at bit 1 and IM[7:0] at bits 15:8; all other bits read 0 and are not writable.
REQ-019 Cause SHALL have ExcCode at bits 6:2 and IP[7:0] at bits 15:8; all other bits read 0.
REQ-020 IP[1:0] SHALL be software bits, writable only by mtc0 to Cause; mtc0 to Cause SHALL NOT alter IP[7:2] or ExcCode.
REQ-021 Each irq_in[i] SHALL pass through a 2-flop synchronizer plus one history flop.
- A rising edge (sync2 & ~hist) sets IP[2+i].
- Line high before edge 0 gives IP set after edge 2.
- Level held high does not re-set IP once cleared.
REQ-022 Count SHALL increment by 1 every cycle and wrap from FFFF_FFFF to 0; mtc0 to Count loads wdata instead of incrementing.
REQ-023 When the pre-increment Count equals Compare, IP[7] SHALL be set; mtc0 to Compare SHALL load Compare and clear IP[7].
- The clear wins over a same-cycle match.
REQ-024 On exc: EPC <= pc_in; ExcCode <= (cause_sel ? 0 : 8); EXL <= 1.
REQ-025 On eret: EXL <= 0.
REQ-026 On inta: the lowest-indexed bit i with IP[i] & IM[i] SHALL be cleared; with no such bit, nothing changes.
REQ-027 Priority per bit, highest first:
- reset
- hardware set (irq edge, timer match)
- inta clear / Compare-write clear
- mtc0 write
REQ-028 When exc and mtc0 coincide, exc SHALL win for Status.EXL, EPC and ExcCode; mtc0 still updates the other fields it targets.
REQ-029 When exc and eret coincide, exc SHALL win (EXL = 1).
REQ-030 rdata, status, epc and int_req SHALL reflect register contents the cycle after an update; there is no read-during-write bypass.

Reset
REQ-031 On reset: Status, Cause, EPC, Count = 0; Compare = FFFF_FFFF; synchronizer and history flops = 0; int_req = 0.
REQ-032 Reset asserted mid-exception SHALL clear EXL and all pending IP.
- After release, a still-high irq_in SHALL produce a new edge 3 cycles later.

Verification
REQ-033 Enable interrupts: mtc0 sel=12 wdata=0000_0401 (IE=1, IM[2]=1); raise irq_in[0] -> IP[2]=1 and int_req=1 exactly 3 edges after the rise.
REQ-034 Exception entry: exc=1, cause_sel=1, pc_in=0000_0040 -> epc=0000_0040, Cause[6:2]=0, EXL=1, int_req=0.
- Then eret -> EXL=0 and int_req=1 again.
REQ-035 Acknowledge priority: IP[2] and IP[4] pending and enabled, inta -> IP[2] cleared, IP[4] still 1.
- Second inta -> IP=0.
REQ-036 Timer: mtc0 Count=0000_0010, Compare=0000_0014 -> IP[7] set on the edge where Count reads 0000_0014.
- mtc0 Compare -> IP[7]=0.
REQ-037 Syscall: exc=1, cause_sel=0 with a simultaneous mtc0 sel=12 wdata=0 -> ExcCode=8, EXL=1, IE=0.
REQ-038 Mid-operation reset: reset asserted with IP[3]=1 and EXL=1 -> all outputs 0 within the same cycle, Compare reads FFFF_FFFF.
